// File: rtl/pcpi_serial_issue_ctrl.sv
// Nibble-serial PCPI sequencer: loads 8 strobed nibbles, issues the instruction, drains the result bytewise.
// Optional issue watchdog: define PCPI_TIMEOUT_EN.

module pcpi_serial_issue_ctrl #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  nib_in_i,
  input  logic        nib_stb_i,
  input  logic        rd_stb_i,
  output logic        pcpi_valid_o,
  output logic [31:0] pcpi_insn_o,
  input  logic        pcpi_ready_i,
  input  logic        pcpi_wr_i,
  input  logic [31:0] pcpi_rd_i,
  input  logic        pcpi_wait_i,
  output logic [7:0]  res_byte_o,
  output logic        res_valid_o,
  output logic [2:0]  nib_cnt_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  logic [SYNC_STAGES-1:0]      nib_stb_sync_q;
  logic [SYNC_STAGES-1:0]      rd_stb_sync_q;
  logic [SYNC_STAGES-1:0][3:0] nib_sync_q;
  logic                        nib_stb_hist_q;
  logic                        rd_stb_hist_q;
  logic                        nib_edge_s;
  logic                        rd_edge_s;
  logic [3:0]                  nib_data_s;

  state_e      state_q, state_d;
  logic [2:0]  nib_cnt_q, nib_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_byte_q, res_byte_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

`ifdef PCPI_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`else
  logic       unused_wait_s;
  assign unused_wait_s = pcpi_wait_i;
`endif

  // Pin synchronizers; data travels with its strobe so the captured nibble is aligned
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      nib_stb_sync_q <= '0;
      rd_stb_sync_q  <= '0;
      nib_sync_q     <= '0;
      nib_stb_hist_q <= 1'b0;
      rd_stb_hist_q  <= 1'b0;
    end else begin
      nib_stb_sync_q[0] <= nib_stb_i;
      rd_stb_sync_q[0]  <= rd_stb_i;
      nib_sync_q[0]     <= nib_in_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        nib_stb_sync_q[i] <= nib_stb_sync_q[i-1];
        rd_stb_sync_q[i]  <= rd_stb_sync_q[i-1];
        nib_sync_q[i]     <= nib_sync_q[i-1];
      end
      nib_stb_hist_q <= nib_stb_sync_q[SYNC_STAGES-1];
      rd_stb_hist_q  <= rd_stb_sync_q[SYNC_STAGES-1];
    end
  end

  assign nib_edge_s = nib_stb_sync_q[SYNC_STAGES-1] & ~nib_stb_hist_q;
  assign rd_edge_s  = rd_stb_sync_q[SYNC_STAGES-1] & ~rd_stb_hist_q;
  assign nib_data_s = nib_sync_q[SYNC_STAGES-1];

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    nib_cnt_d   = nib_cnt_q;
    idx_d       = idx_q;
    insn_d      = insn_q;
    result_d    = result_q;
    valid_d     = valid_q;
    res_valid_d = res_valid_q;
    res_byte_d  = res_byte_q;
    done_d      = 1'b0;
`ifdef PCPI_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (nib_edge_s) begin
          insn_d[{nib_cnt_q, 2'b00} +: 4] = nib_data_s;
          nib_cnt_d = nib_cnt_q + 3'd1;
`ifdef PCPI_TIMEOUT_EN
          if (nib_cnt_q == 3'd0) begin
            err_d = 1'b0;
          end else begin
            err_d = err_q;
          end
`endif
          if (nib_cnt_q == 3'd7) begin
            state_d = ST_ISSUE;
            valid_d = 1'b1;
`ifdef PCPI_TIMEOUT_EN
            tmo_d   = 8'd0;
`endif
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ISSUE: begin
        // Strobe edges are consumed by the history flops here and never replayed
        if (pcpi_ready_i && valid_q) begin
          valid_d = 1'b0;
          if (pcpi_wr_i) begin
            result_d    = pcpi_rd_i;
            idx_d       = 2'd0;
            res_valid_d = 1'b1;
            res_byte_d  = pcpi_rd_i[7:0];
            state_d     = ST_DRAIN;
          end else begin
            done_d  = 1'b1;
            state_d = ST_LOAD;
          end
        end
`ifdef PCPI_TIMEOUT_EN
        else if (pcpi_wait_i) begin
          tmo_d = 8'd0;
        end else if (tmo_q == TMO_LAST) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_LOAD;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`else
        else begin
          state_d = ST_ISSUE;
        end
`endif
      end
      ST_DRAIN: begin
        if (rd_edge_s) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            res_valid_d = 1'b0;
            res_byte_d  = 8'h00;
            done_d      = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            res_byte_d = result_q[{idx_d, 3'b000} +: 8];
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_LOAD;
        nib_cnt_d   = 3'd0;
        idx_d       = 2'd0;
        valid_d     = 1'b0;
        res_valid_d = 1'b0;
        res_byte_d  = 8'h00;
      end
    endcase
    busy_d = !((state_d == ST_LOAD) && (nib_cnt_d == 3'd0));
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_LOAD;
      nib_cnt_q   <= 3'd0;
      idx_q       <= 2'd0;
      insn_q      <= 32'h0;
      result_q    <= 32'h0;
      valid_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_byte_q  <= 8'h00;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nib_cnt_q   <= nib_cnt_d;
      idx_q       <= idx_d;
      insn_q      <= insn_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      res_valid_q <= res_valid_d;
      res_byte_q  <= res_byte_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PCPI_TIMEOUT_EN
  // Watchdog counter and sticky error
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign pcpi_valid_o = valid_q;
  assign pcpi_insn_o  = insn_q;
  assign res_byte_o   = res_byte_q;
  assign res_valid_o  = res_valid_q;
  assign nib_cnt_o    = nib_cnt_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_pcpi_serial_issue_ctrl.sv
// Randomized self-checking bench for pcpi_serial_issue_ctrl; expectations come from nibble/byte arithmetic.
// Watchdog scenario is exercised when PCPI_TIMEOUT_EN is defined.

module tb_pcpi_serial_issue_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  nib_in = 4'h0;
  logic        nib_stb = 1'b0;
  logic        rd_stb = 1'b0;
  logic        pcpi_ready = 1'b0;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = 32'h0;
  logic        pcpi_wait = 1'b1;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [7:0]  res_byte;
  logic        res_valid;
  logic [2:0]  nib_cnt;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  pcpi_serial_issue_ctrl #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .nib_in_i(nib_in), .nib_stb_i(nib_stb), .rd_stb_i(rd_stb),
    .pcpi_valid_o(pcpi_valid), .pcpi_insn_o(pcpi_insn), .pcpi_ready_i(pcpi_ready),
    .pcpi_wr_i(pcpi_wr), .pcpi_rd_i(pcpi_rd), .pcpi_wait_i(pcpi_wait),
    .res_byte_o(res_byte), .res_valid_o(res_valid), .nib_cnt_o(nib_cnt),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return 8'(w >> (8 * k));
  endfunction

  task automatic send_nib(input logic [3:0] n, input logic [2:0] cnt_b, input logic v_b,
                          input logic [2:0] cnt_a, input logic v_a);
    nib_in = n;
    nib_stb = 1'b1;
    repeat (SYNC) tick();
    n_cmp++;
    if ({nib_cnt, pcpi_valid} !== {cnt_b, v_b}) begin
      n_err++;
      $display("FAIL nib_pre: cnt/valid got %0d/%0b exp %0d/%0b", nib_cnt, pcpi_valid, cnt_b, v_b);
    end
    tick();
    n_cmp++;
    if ({nib_cnt, pcpi_valid} !== {cnt_a, v_a}) begin
      n_err++;
      $display("FAIL nib_post: cnt/valid got %0d/%0b exp %0d/%0b", nib_cnt, pcpi_valid, cnt_a, v_a);
    end
    tick();
    nib_stb = 1'b0;
    repeat (SYNC + 2) tick();
  endtask

  task automatic load_nibs(input logic [3:0] nibs [8], output logic [31:0] exp_insn);
    exp_insn = 32'h0;
    for (int k = 0; k < 8; k++) begin
      exp_insn = exp_insn + (32'(nibs[k]) << (4 * k));
      send_nib(nibs[k], 3'(k), 1'b0, 3'((k + 1) % 8), (k == 7));
    end
    n_cmp++;
    if (pcpi_insn !== exp_insn) begin
      n_err++;
      $display("FAIL load_insn: got %h exp %h", pcpi_insn, exp_insn);
    end
  endtask

  task automatic rd_pulse(input logic [7:0] b_pre, input logic [7:0] b_post,
                          input logic rv_post, input logic done_post);
    rd_stb = 1'b1;
    repeat (SYNC) tick();
    n_cmp++;
    if (res_byte !== b_pre) begin
      n_err++;
      $display("FAIL rd_pre: byte got %h exp %h", res_byte, b_pre);
    end
    tick();
    n_cmp++;
    if ({res_byte, res_valid, done} !== {b_post, rv_post, done_post}) begin
      n_err++;
      $display("FAIL rd_post: byte/rv/done got %h/%0b/%0b exp %h/%0b/%0b",
               res_byte, res_valid, done, b_post, rv_post, done_post);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL rd_done_pulse: done got %0b exp 0", done);
    end
    rd_stb = 1'b0;
    repeat (SYNC + 2) tick();
  endtask

  task automatic complete(input logic wr, input logic [31:0] rd);
    pcpi_ready = 1'b1;
    pcpi_wr = wr;
    pcpi_rd = rd;
    tick();
    pcpi_ready = 1'b0;
    pcpi_wr = 1'b0;
    n_cmp++;
    if ({pcpi_valid, res_valid, done, res_byte, busy} !== {1'b0, wr, !wr, (wr ? rd[7:0] : 8'h00), wr}) begin
      n_err++;
      $display("FAIL complete: valid/rv/done/byte/busy got %0b/%0b/%0b/%h/%0b exp 0/%0b/%0b/%h/%0b",
               pcpi_valid, res_valid, done, res_byte, busy, wr, !wr, (wr ? rd[7:0] : 8'h00), wr);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL complete_done_pulse: done got %0b exp 0", done);
    end
  endtask

  task automatic drain_all(input logic [31:0] res);
    for (int k = 1; k <= 4; k++) begin
      rd_pulse(byte_of(res, k - 1), (k < 4) ? byte_of(res, k) : 8'h00, (k < 4), (k == 4));
    end
    n_cmp++;
    if ({busy, nib_cnt, res_valid} !== {1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL drain_end: busy/cnt/rv got %0b/%0d/%0b exp 0/0/0", busy, nib_cnt, res_valid);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({pcpi_valid, pcpi_insn, res_byte, res_valid, nib_cnt, busy, done, err} !== 48'h0) begin
      n_err++;
      $display("FAIL %s: valid=%0b insn=%h byte=%h rv=%0b cnt=%0d busy=%0b done=%0b err=%0b exp all 0",
               tag, pcpi_valid, pcpi_insn, res_byte, res_valid, nib_cnt, busy, done, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    check_all_zero("after_reset");
  endtask

  task automatic test_load_issue_drain();
    logic [3:0]  nibs [8];
    logic [31:0] e;
    nibs = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
    load_nibs(nibs, e);
    n_cmp++;
    if ({pcpi_insn, pcpi_valid, busy} !== {32'h1234ABCD, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL directed_load: insn/valid/busy got %h/%0b/%0b exp 1234abcd/1/1", pcpi_insn, pcpi_valid, busy);
    end
    repeat (3) tick();
    complete(1'b1, 32'hDEADBEEF);
    drain_all(32'hDEADBEEF);
  endtask

  task automatic test_no_write();
    logic [3:0]  nibs [8];
    logic [31:0] e;
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    tick();
    complete(1'b0, $urandom);
    n_cmp++;
    if ({nib_cnt, res_valid, res_byte, pcpi_insn} !== {3'd0, 1'b0, 8'h00, e}) begin
      n_err++;
      $display("FAIL no_write: cnt/rv/byte/insn got %0d/%0b/%h/%h exp 0/0/00/%h", nib_cnt, res_valid, res_byte, pcpi_insn, e);
    end
  endtask

  task automatic test_ignored_strobes();
    logic [3:0]  nibs [8];
    logic [31:0] e;
    logic [31:0] r;
    pcpi_ready = 1'b1;
    pcpi_wr = 1'b1;
    pcpi_rd = 32'hFFFF_FFFF;
    tick();
    pcpi_ready = 1'b0;
    pcpi_wr = 1'b0;
    n_cmp++;
    if ({res_valid, nib_cnt, pcpi_valid} !== {1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL ready_in_load: rv/cnt/valid got %0b/%0d/%0b exp 0/0/0", res_valid, nib_cnt, pcpi_valid);
    end
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    send_nib(~nibs[0], 3'd0, 1'b1, 3'd0, 1'b1);
    rd_stb = 1'b1;
    repeat (SYNC + 2) tick();
    rd_stb = 1'b0;
    repeat (SYNC + 2) tick();
    n_cmp++;
    if ({pcpi_insn, pcpi_valid, res_valid} !== {e, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL issue_ignore: insn/valid/rv got %h/%0b/%0b exp %h/1/0", pcpi_insn, pcpi_valid, res_valid, e);
    end
    r = $urandom;
    complete(1'b1, r);
    send_nib(4'h5, 3'd0, 1'b0, 3'd0, 1'b0);
    n_cmp++;
    if ({res_byte, res_valid} !== {byte_of(r, 0), 1'b1}) begin
      n_err++;
      $display("FAIL drain_ignore: byte/rv got %h/%0b exp %h/1", res_byte, res_valid, byte_of(r, 0));
    end
    drain_all(r);
  endtask

  task automatic test_coincident();
    logic [3:0]  nibs [8];
    logic [31:0] e;
    logic [31:0] r;
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    r = $urandom;
    rd_stb = 1'b1;
    repeat (SYNC) tick();
    pcpi_ready = 1'b1;
    pcpi_wr = 1'b1;
    pcpi_rd = r;
    tick();
    pcpi_ready = 1'b0;
    pcpi_wr = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({res_byte, res_valid} !== {byte_of(r, 0), 1'b1}) begin
      n_err++;
      $display("FAIL coincident_rd: byte/rv got %h/%0b exp %h/1", res_byte, res_valid, byte_of(r, 0));
    end
    rd_stb = 1'b0;
    repeat (SYNC + 2) tick();
    drain_all(r);
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    nib_in = 4'hF;
    nib_stb = 1'b1;
    repeat (SYNC) tick();
    pcpi_ready = 1'b1;
    tick();
    pcpi_ready = 1'b0;
    n_cmp++;
    if ({done, nib_cnt} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL coincident_nib: done/cnt got %0b/%0d exp 1/0", done, nib_cnt);
    end
    repeat (3) tick();
    nib_stb = 1'b0;
    repeat (SYNC + 2) tick();
    n_cmp++;
    if ({nib_cnt, pcpi_insn, busy} !== {3'd0, e, 1'b0}) begin
      n_err++;
      $display("FAIL coincident_nib_drop: cnt/insn/busy got %0d/%h/%0b exp 0/%h/0", nib_cnt, pcpi_insn, busy, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  nibs [8];
    logic [31:0] e;
    logic [31:0] r;
    for (int k = 0; k < 5; k++) send_nib(4'($urandom_range(1, 15)), 3'(k), 1'b0, 3'(k + 1), 1'b0);
    rst_n = 1'b0;
    tick();
    check_all_zero("reset_in_load");
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    r = $urandom;
    complete(1'b1, r);
    rd_pulse(byte_of(r, 0), byte_of(r, 1), 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_all_zero("reset_in_drain");
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    r = $urandom;
    complete(1'b1, r);
    drain_all(r);
  endtask

  task automatic test_random();
    logic [3:0]  nibs [8];
    logic [31:0] e;
    logic [31:0] r;
    logic        wr;
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
      load_nibs(nibs, e);
      repeat ($urandom_range(0, 4)) tick();
      wr = 1'($urandom_range(0, 1));
      r = $urandom;
      complete(wr, r);
      if (wr) drain_all(r);
      else tick();
    end
  endtask

  task automatic test_timeout();
    logic [3:0]  nibs [8];
    logic [31:0] e;
`ifdef PCPI_TIMEOUT_EN
    pcpi_wait = 1'b0;
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    repeat (4) tick();
    n_cmp++;
    if ({pcpi_valid, err} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL tmo_before: valid/err got %0b/%0b exp 1/0", pcpi_valid, err);
    end
    tick();
    n_cmp++;
    if ({pcpi_valid, err, done, res_valid, busy} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL tmo_fire: valid/err/done/rv/busy got %0b/%0b/%0b/%0b/%0b exp 0/1/1/0/0",
               pcpi_valid, err, done, res_valid, busy);
    end
    repeat (3) tick();
    n_cmp++;
    if ({err, done} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL tmo_sticky: err/done got %0b/%0b exp 1/0", err, done);
    end
    send_nib(4'h3, 3'd0, 1'b0, 3'd1, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_clear: err got %0b exp 0", err);
    end
    for (int k = 1; k < 8; k++) send_nib(4'(k), 3'(k), 1'b0, 3'((k + 1) % 8), (k == 7));
    pcpi_wait = 1'b1;
    repeat (20) tick();
    n_cmp++;
    if ({pcpi_valid, err} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL tmo_wait: valid/err got %0b/%0b exp 1/0", pcpi_valid, err);
    end
    pcpi_wait = 1'b0;
    complete(1'b0, 32'h0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_wait_done: err got %0b exp 0", err);
    end
    pcpi_wait = 1'b1;
`else
    pcpi_wait = 1'b0;
    for (int k = 0; k < 8; k++) nibs[k] = 4'($urandom_range(0, 15));
    load_nibs(nibs, e);
    repeat (300) tick();
    n_cmp++;
    if ({pcpi_valid, err, pcpi_insn} !== {1'b1, 1'b0, e}) begin
      n_err++;
      $display("FAIL no_tmo: valid/err/insn got %0b/%0b/%h exp 1/0/%h", pcpi_valid, err, pcpi_insn, e);
    end
    complete(1'b0, 32'h0);
    pcpi_wait = 1'b1;
`endif
  endtask

  initial begin
    test_reset();
    test_load_issue_drain();
    test_no_write();
    test_ignored_strobes();
    test_coincident();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcpi_serial_issue_ctrl.md
Name: pcpi_serial_issue_ctrl

Overview:
- Sequencer between the pin-limited TinyTapeout top and a PCPI coprocessor datapath.
- Assembles a 32-bit instruction from 8 strobed input nibbles and issues it on the PCPI interface.
- Waits for the coprocessor's completion, then serves the 32-bit result back out one byte per read strobe.
- Sits inside the top module: ui_in carries nibble/strobe, uio_out carries result bytes.

Parameters:
- SYNC_STAGES, 2, flop depth of the input synchronizer on nib_stb, rd_stb and nib_in (min 1).
- TIMEOUT_CYCLES, 255, issue watchdog limit in cycles; used only with PCPI_TIMEOUT_EN; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- nib_in  in  4  instruction nibble from pins
- nib_stb  in  1  nibble strobe, asynchronous level; rising edge = nibble present
- rd_stb  in  1  result-read strobe, asynchronous level; rising edge = byte consumed
- pcpi_valid  out  1  instruction valid to coprocessor
- pcpi_insn  out  32  assembled instruction
- pcpi_ready  in  1  coprocessor done
- pcpi_wr  in  1  coprocessor writes a result
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  coprocessor busy, extends timeout
- res_byte  out  8  current result byte; 0 when res_valid=0
- res_valid  out  1  result bytes available
- nib_cnt  out  3  nibbles captured so far
- busy  out  1  1 unless in LOAD with nib_cnt=0
- done  out  1  one-cycle pulse at transaction end
- err  out  1  sticky timeout flag

Behaviour:
- Reset, synchronous, when rst_n sampled low: state=LOAD; nib_cnt, byte index, pcpi_insn and result register = 0. Outputs pcpi_valid, res_valid, done and err = 0. Takes effect mid-transaction with no PCPI completion required.
- Synchronizer: nib_stb, rd_stb and nib_in each pass through SYNC_STAGES flops, then one history flop for edge detect. Nibble data is therefore aligned with its strobe.
- A strobe edge acts SYNC_STAGES+1 rising clk edges after the first edge that samples the pin high. Pins must be held stable for at least SYNC_STAGES+2 cycles.
- States (2-bit encoding): LOAD=00, ISSUE=01, DRAIN=10; 11 is unreachable and recovers to LOAD.
- LOAD:
  - On a nib_stb edge, pcpi_insn[4*nib_cnt +: 4] <= nibble. Nibble 0 fills bits 3:0 (little-nibble order).
  - nib_cnt increments on each capture.
  - On the capture with nib_cnt=7: nib_cnt wraps to 0, state -> ISSUE, pcpi_valid=1 the next cycle.
  - rd_stb edges are ignored.
- ISSUE:
  - pcpi_valid stays 1 and pcpi_insn stays stable until the first cycle with pcpi_ready=1.
  - pcpi_valid is 0 on the following cycle.
  - pcpi_ready with pcpi_wr=1: result <= pcpi_rd, byte index=0, res_valid=1, state -> DRAIN.
  - pcpi_ready with pcpi_wr=0: done pulse, state -> LOAD, res_valid stays 0.
  - nib_stb and rd_stb edges are ignored; edges are not queued.
- DRAIN:
  - res_byte = result[8*idx +: 8], driven from registers.
  - On an rd_stb edge: idx increments.
  - On the edge with idx=3: res_valid=0, done pulse, state -> LOAD.
  - nib_stb edges are ignored.
- Simultaneous events: pcpi_ready arriving in the same cycle as a strobe edge → ready wins; the strobe is dropped.
- pcpi_ready while pcpi_valid=0 → ignored.
- Pins are not combinationally forwarded to any output.

Optional Feature:
- Macro: PCPI_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ISSUE and on any cycle with pcpi_wait=1; otherwise it increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES with pcpi_ready still 0: pcpi_valid=0 next cycle, err=1, done pulse, state -> LOAD, result unchanged.
  - err clears on the first nibble capture of the next instruction, or on reset.
- Undefined: no counter; err tied 0; ISSUE waits indefinitely; pcpi_wait unused.

Test Plan:
- Load: reset, then send nibbles D,C,B,A,4,3,2,1.
  - pcpi_insn=0x1234ABCD and pcpi_valid=1 exactly one cycle after the 8th capture.
  - nib_cnt reads 1..7 then 0.
- Issue and drain: with the load above, assert pcpi_ready=1, pcpi_wr=1, pcpi_rd=0xDEADBEEF 3 cycles later.
  - pcpi_valid=0 the next cycle; res_valid=1; res_byte=0xEF.
  - rd_stb edges give 0xBE, 0xAD, 0xDE, then done pulse, res_valid=0, busy=0.
- No-write completion: pcpi_ready=1, pcpi_wr=0.
  - done pulse, state LOAD, res_valid=0, res_byte=0.
- Ignored strobes: nib_stb and rd_stb edges during ISSUE, and nib_stb during DRAIN.
  - pcpi_insn, nib_cnt and idx unchanged.
  - A strobe coincident with pcpi_ready is dropped.
- Reset mid-operation: pull rst_n low after 5 nibbles, and again in DRAIN.
  - All outputs 0 the next cycle; a fresh 8-nibble load then issues correctly.
- PCPI_TIMEOUT_EN with TIMEOUT_CYCLES=10: never assert ready.
  - err=1 and pcpi_valid=0 after 10 ISSUE cycles.
  - Holding pcpi_wait=1 for 20 cycles, then ready, completes with no err.
  - err clears on the next nibble capture.
